// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding,
// the default fetch-starvation bound and the starvation counter width helper.
package mem_arb_pkg;

   localparam int STARVE_MAX_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE_I = 3'd1,
      ST_WAIT_I  = 3'd2,
      ST_ISSUE_D = 3'd3,
      ST_WAIT_D  = 3'd4
   } arb_state_e;

   function automatic int starve_w(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating up-counter of data grants made while a fetch is waiting.
// sat tells the arbiter that data may no longer jump ahead of fetch.
module mem_arb_starve_cnt #(
   parameter int MAX = 4,
   parameter int W   = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign sat = (cnt_q >= W'(MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !sat) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes fetch and data requests onto one variable-latency memory port,
// data first with bounded fetch starvation, and discards flushed fetches.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iReq,
   input  logic [15:0] iAddr,
   input  logic        iFlush,
   output logic        iDone,
   output logic [15:0] iData,
   output logic        iStall,
   input  logic        dRd,
   input  logic        dWr,
   input  logic [15:0] dAddr,
   input  logic [15:0] dWData,
   output logic        dDone,
   output logic [15:0] dRData,
   output logic        dStall,
   output logic        mRd,
   output logic        mWr,
   output logic [15:0] mAddr,
   output logic [15:0] mWData,
   input  logic        mStall,
   input  logic        mDone,
   input  logic [15:0] mRData
);

   arb_state_e  state_q, state_d;
   logic        kill_q, kill_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;

   logic d_req, in_idle, d_win, i_win, starve_sat;

   assign d_req   = dRd | dWr;
   assign in_idle = (state_q == ST_IDLE);
   assign d_win   = in_idle & d_req & (~iReq | ~starve_sat);
   assign i_win   = in_idle & ~d_win & iReq & ~iFlush;

   mem_arb_starve_cnt #(
      .MAX (STARVE_MAX),
      .W   (starve_w(STARVE_MAX))
   ) u_starve (
      .clk (clk),
      .rst (rst),
      .inc (d_win & iReq),
      .clr (i_win | (in_idle & ~iReq)),
      .sat (starve_sat)
   );

   assign mAddr  = addr_q;
   assign mWData = wdata_q;
   assign iStall = iReq & ~iDone;
   assign dStall = d_req & ~dDone;

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mRd     = 1'b0;
      mWr     = 1'b0;
      iDone   = 1'b0;
      iData   = '0;
      dDone   = 1'b0;
      dRData  = '0;
      case (state_q)
         ST_IDLE: begin
            if (d_win) begin
               state_d = ST_ISSUE_D;
               addr_d  = dAddr;
               wdata_d = dWData;
               wr_d    = dWr;
            end else if (i_win) begin
               state_d = ST_ISSUE_I;
               addr_d  = iAddr;
               wdata_d = '0;
               wr_d    = 1'b0;
            end
         end
         // A flush here withdraws the read before the memory can accept it.
         ST_ISSUE_I: begin
            if (iFlush) begin
               state_d = ST_IDLE;
            end else begin
               mRd = 1'b1;
               if (!mStall) state_d = ST_WAIT_I;
            end
         end
         ST_WAIT_I: begin
            if (mDone) begin
               state_d = ST_IDLE;
               kill_d  = 1'b0;
               if (!kill_q && !iFlush) begin
                  iDone = 1'b1;
                  iData = mRData;
               end
            end else if (iFlush) begin
               kill_d = 1'b1;
            end
         end
         ST_ISSUE_D: begin
            mWr = wr_q;
            mRd = ~wr_q;
            if (!mStall) state_d = ST_WAIT_D;
         end
         ST_WAIT_D: begin
            if (mDone) begin
               state_d = ST_IDLE;
               dDone   = 1'b1;
               dRData  = mRData;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         kill_q  <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and
// a randomized run against a transaction-level memory/requester reference.
module tb_mem_arbiter;

   localparam int SMAX = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        iReq, iFlush, iDone, iStall;
   logic [15:0] iAddr, iData;
   logic        dRd, dWr, dDone, dStall;
   logic [15:0] dAddr, dWData, dRData;
   logic        mRd, mWr, mStall, mDone;
   logic [15:0] mAddr, mWData, mRData;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .iReq(iReq), .iAddr(iAddr), .iFlush(iFlush), .iDone(iDone), .iData(iData), .iStall(iStall),
      .dRd(dRd), .dWr(dWr), .dAddr(dAddr), .dWData(dWData), .dDone(dDone), .dRData(dRData),
      .dStall(dStall),
      .mRd(mRd), .mWr(mWr), .mAddr(mAddr), .mWData(mWData), .mStall(mStall), .mDone(mDone),
      .mRData(mRData)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- memory contents: device copy and reference copy ----------------
   logic [15:0] dev_mem[int];
   logic [15:0] ref_mem[int];

   function automatic logic [15:0] init_val(input logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h1234;
   endfunction

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
   endfunction

   function automatic logic [15:0] dev_rd(input logic [15:0] a);
      return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : init_val(a);
   endfunction

   // ---------------- behavioural memory device ----------------
   int          stall_cfg = 0;
   int          lat_cfg   = 1;
   bit          rnd_mem   = 1'b0;
   bit          pend, p_wr, cmd_prev;
   int          cnt, stall_left;
   logic [15:0] p_addr;

   initial begin
      mStall = 1'b0; mDone = 1'b0; mRData = '0;
      pend = 1'b0; cmd_prev = 1'b0; stall_left = 0; cnt = 0; p_wr = 1'b0; p_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 1'b0; cmd_prev = 1'b0; stall_left = 0;
         end else begin
            if ((mRd | mWr) && !mStall && !pend) begin
               pend   = 1'b1;
               cnt    = rnd_mem ? int'($urandom_range(1, 4)) : lat_cfg;
               p_addr = mAddr;
               p_wr   = mWr;
               if (mWr) dev_mem[int'(mAddr)] = mWData;
            end
            if (mStall && stall_left > 0) stall_left--;
            cmd_prev = mRd | mWr;
         end
         @(posedge clk);
         #2;
         mDone  = 1'b0;
         mRData = '0;
         if (pend && !rst) begin
            cnt--;
            if (cnt == 0) begin
               mDone = 1'b1;
               if (!p_wr) mRData = dev_rd(p_addr);
               pend = 1'b0;
            end
         end
         if ((mRd | mWr) && !cmd_prev)
            stall_left = rnd_mem ? int'($urandom_range(0, 2)) : stall_cfg;
         mStall = (mRd | mWr) && (stall_left > 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        is_d;
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          stall;
      int          mlat;
      int          exp_cyc;
      logic        exp_mrd;
      logic        exp_mwr;
      logic        chk_data;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input vec_t v, input int idx);
      int c;
      bit done;
      stall_cfg = v.stall;
      lat_cfg   = v.mlat;
      if (v.is_d) begin
         dRd = v.rd; dWr = v.wr; dAddr = v.addr; dWData = v.wdata;
      end else begin
         iReq = 1'b1; iAddr = v.addr;
      end
      c = 0;
      done = 1'b0;
      while (!done && c < 40) begin
         @(negedge clk);
         if (c >= 1 && c <= 1 + v.stall) begin
            chk($sformatf("vec%0d_mrd_c%0d", idx, c), 32'(mRd), 32'(v.exp_mrd));
            chk($sformatf("vec%0d_mwr_c%0d", idx, c), 32'(mWr), 32'(v.exp_mwr));
            chk($sformatf("vec%0d_maddr_c%0d", idx, c), 32'(mAddr), 32'(v.addr));
            if (v.exp_mwr) chk($sformatf("vec%0d_mwdata", idx), 32'(mWData), 32'(v.wdata));
         end
         if (v.is_d ? dDone : iDone) begin
            done = 1'b1;
            chk($sformatf("vec%0d_latency", idx), 32'(c), 32'(v.exp_cyc));
            chk($sformatf("vec%0d_stall_at_done", idx), 32'(v.is_d ? dStall : iStall), 32'(0));
            if (v.chk_data)
               chk($sformatf("vec%0d_data", idx), 32'(v.is_d ? dRData : iData), 32'(v.exp_data));
            if (v.is_d && v.wr) ref_mem[int'(v.addr)] = v.wdata;
         end else begin
            chk($sformatf("vec%0d_stall_c%0d", idx, c), 32'(v.is_d ? dStall : iStall), 32'(1));
         end
         cyc();
         c++;
      end
      if (!done) chk($sformatf("vec%0d_timeout", idx), 32'(0), 32'(1));
      iReq = 1'b0; dRd = 1'b0; dWr = 1'b0;
      cyc();
      cyc();
   endtask

   // ---------------- main sequence ----------------
   bit   grants[$];
   bit   exp_g[6];
   bit   dd, id, prevcmd, idone_p, ddone_p, ireq_p, keep;
   int   n, scnt, iwait, dwait, k;

   initial begin
      rst = 1'b1;
      iReq = 1'b0; iAddr = '0; iFlush = 1'b0;
      dRd = 1'b0; dWr = 1'b0; dAddr = '0; dWData = '0;
      dev_mem[16'h0010] = 16'h1234; ref_mem[16'h0010] = 16'h1234;
      dev_mem[16'h8004] = 16'hCAFE; ref_mem[16'h8004] = 16'hCAFE;
      dev_mem[16'h0014] = 16'h0F0F; ref_mem[16'h0014] = 16'h0F0F;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 2, 3, 1'b1, 1'b0, 1'b1, 16'h1234};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h8004, 16'h0000, 0, 1, 2, 1'b1, 1'b0, 1'b1, 16'hCAFE};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h8008, 16'h5555, 1, 1, 3, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h8008, 16'h0000, 0, 3, 4, 1'b1, 1'b0, 1'b1, 16'h5555};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h800C, 16'h7777, 0, 1, 2, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h800C, 16'h0000, 3, 1, 5, 1'b1, 1'b0, 1'b1, 16'h7777};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0014, 16'h0000, 2, 1, 4, 1'b1, 1'b0, 1'b1, 16'h0F0F};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mrd", 32'(mRd), 0);     chk("rst_mwr", 32'(mWr), 0);
      chk("rst_maddr", 32'(mAddr), 0); chk("rst_mwdata", 32'(mWData), 0);
      chk("rst_idone", 32'(iDone), 0); chk("rst_ddone", 32'(dDone), 0);
      chk("rst_idata", 32'(iData), 0); chk("rst_drdata", 32'(dRData), 0);
      chk("rst_istall", 32'(iStall), 0); chk("rst_dstall", 32'(dStall), 0);
      cyc();
      rst = 1'b0;
      cyc();

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Simultaneous fetch and data write: write goes first, fetch after dDone.
      stall_cfg = 0; lat_cfg = 1;
      iReq = 1'b1; iAddr = 16'h0020;
      dWr = 1'b1; dAddr = 16'h8000; dWData = 16'hBEEF;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("both_mwr", 32'(mWr), 1);          chk("both_mrd_c1", 32'(mRd), 0);
            chk("both_maddr_d", 32'(mAddr), 32'h8000); chk("both_mwdata", 32'(mWData), 32'hBEEF);
         end
         if (c == 2) begin
            chk("both_ddone", 32'(dDone), 1); chk("both_idone_c2", 32'(iDone), 0);
            chk("both_istall_c2", 32'(iStall), 1);
         end
         if (c == 4) begin
            chk("both_mrd_i", 32'(mRd), 1); chk("both_maddr_i", 32'(mAddr), 32'h0020);
         end
         if (c == 5) begin
            chk("both_idone", 32'(iDone), 1); chk("both_idata", 32'(iData), 32'(ref_rd(16'h0020)));
         end
         cyc();
         if (c == 2) dWr = 1'b0;
      end
      ref_mem[16'h8000] = 16'hBEEF;
      iReq = 1'b0;
      cyc(); cyc();

      // Starvation bound of 2: continuous data reads with fetch held.
      exp_g = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      grants.delete();
      iReq = 1'b1; iAddr = 16'h0030;
      dRd = 1'b1; dAddr = 16'h8100;
      n = 0; dd = 1'b0; id = 1'b0; prevcmd = 1'b0; keep = 1'b1;
      for (int c = 0; c < 300 && (iReq || dRd); c++) begin
         @(negedge clk);
         if ((mRd | mWr) && !prevcmd) grants.push_back(mAddr[15]);
         prevcmd = mRd | mWr;
         dd = dDone; id = iDone;
         if (dDone) chk("starve_drdata", 32'(dRData), 32'(ref_rd(dAddr)));
         if (iDone) chk("starve_idata", 32'(iData), 32'(ref_rd(iAddr)));
         if (grants.size() >= 6) keep = 1'b0;
         cyc();
         if (dd) begin
            n++;
            if (keep) dAddr = 16'h8100 + 16'(n); else dRd = 1'b0;
         end
         if (id) begin
            if (keep) iAddr = 16'h0030 + 16'(n); else iReq = 1'b0;
         end
      end
      chk("starve_drained", 32'(iReq | dRd), 0);
      for (int i = 0; i < 6; i++)
         chk($sformatf("grant%0d", i), 32'(i < grants.size() ? grants[i] : 1'bx), 32'(exp_g[i]));
      cyc(); cyc();

      // Flush while the fetch waits for memory: returned data must be discarded.
      lat_cfg = 4;
      iReq = 1'b1; iAddr = 16'h0050;
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         if (c >= 2 && c <= 5) chk($sformatf("flush_no_idone_c%0d", c), 32'(iDone), 0);
         if (c == 5) chk("flush_mdone_seen", 32'(mDone), 1);
         if (c == 6) chk("flush_idle_mrd", 32'(mRd), 0);
         if (c == 7) begin
            chk("flush_refetch_mrd", 32'(mRd), 1); chk("flush_refetch_addr", 32'(mAddr), 32'h0040);
         end
         if (c == 8) begin
            chk("flush_refetch_done", 32'(iDone), 1);
            chk("flush_refetch_data", 32'(iData), 32'(ref_rd(16'h0040)));
         end
         cyc();
         iFlush = 1'b0;
         if (c == 1) begin
            iFlush = 1'b1; iAddr = 16'h0040; lat_cfg = 1;
         end
      end
      iReq = 1'b0;
      cyc(); cyc();

      // Reset while a data read waits for memory.
      lat_cfg = 5;
      dRd = 1'b1; dAddr = 16'h8200;
      cyc(); cyc(); cyc();
      rst = 1'b1;
      #1;
      chk("arst_mrd", 32'(mRd), 0);     chk("arst_mwr", 32'(mWr), 0);
      chk("arst_maddr", 32'(mAddr), 0); chk("arst_mwdata", 32'(mWData), 0);
      chk("arst_ddone", 32'(dDone), 0); chk("arst_drdata", 32'(dRData), 0);
      chk("arst_idone", 32'(iDone), 0); chk("arst_idata", 32'(iData), 0);
      chk("arst_dstall", 32'(dStall), 1);
      lat_cfg = 1;
      cyc();
      rst = 1'b0;
      for (int c = 0; c <= 2; c++) begin
         @(negedge clk);
         if (c == 0) chk("arst_idle_mrd", 32'(mRd), 0);
         if (c == 1) begin
            chk("arst_reissue_mrd", 32'(mRd), 1); chk("arst_reissue_addr", 32'(mAddr), 32'h8200);
         end
         if (c == 2) begin
            chk("arst_ddone_after", 32'(dDone), 1);
            chk("arst_data_after", 32'(dRData), 32'(ref_rd(16'h8200)));
         end
         cyc();
      end
      dRd = 1'b0;
      cyc(); cyc();

      // Randomized traffic against the reference memory and arbitration rules.
      rnd_mem = 1'b1;
      idone_p = 1'b0; ddone_p = 1'b0; prevcmd = 1'b0; ireq_p = 1'b0;
      scnt = 0; iwait = 0; dwait = 0;
      for (int c = 0; c < 3000; c++) begin
         iFlush = 1'b0;
         if (idone_p || !iReq) begin
            iReq  = ($urandom_range(0, 2) != 0);
            iAddr = 16'($urandom_range(0, 15));
         end else if ($urandom_range(0, 9) == 0) begin
            iFlush = 1'b1;
            iAddr  = 16'($urandom_range(0, 15));
         end
         if (ddone_p || !(dRd | dWr)) begin
            k      = int'($urandom_range(0, 5));
            dRd    = (k == 1 || k == 2 || k == 4);
            dWr    = (k == 3 || k == 4 || k == 5);
            dAddr  = 16'h8000 | 16'($urandom_range(0, 15));
            dWData = 16'($urandom);
         end
         @(negedge clk);
         chk("rnd_istall", 32'(iStall), 32'(iReq & ~iDone));
         chk("rnd_dstall", 32'(dStall), 32'((dRd | dWr) & ~dDone));
         chk("rnd_one_done", 32'(iDone & dDone), 0);
         if (iDone) begin
            chk("rnd_idone_req", 32'(iReq), 1);
            chk("rnd_idata", 32'(iData), 32'(ref_rd(iAddr)));
         end else begin
            chk("rnd_idata_zero", 32'(iData), 0);
         end
         if (dDone) begin
            chk("rnd_ddone_req", 32'(dRd | dWr), 1);
            if (dWr) ref_mem[int'(dAddr)] = dWData;
            else chk("rnd_drdata", 32'(dRData), 32'(ref_rd(dAddr)));
         end else begin
            chk("rnd_drdata_zero", 32'(dRData), 0);
         end
         if ((mRd | mWr) && !prevcmd) begin
            if (mAddr[15]) begin
               if (iReq && ireq_p) begin
                  scnt++;
                  chk("rnd_starve_bound", 32'(scnt <= SMAX), 1);
               end
            end else begin
               scnt = 0;
            end
         end
         if (!iReq || iFlush) scnt = 0;
         prevcmd = mRd | mWr;
         ireq_p  = iReq;
         iwait = (iReq && !iDone && !iFlush) ? iwait + 1 : 0;
         dwait = ((dRd | dWr) && !dDone) ? dwait + 1 : 0;
         if (iwait > 100) begin chk("rnd_fetch_timeout", 0, 1); iwait = 0; end
         if (dwait > 100) begin chk("rnd_data_timeout", 0, 1); dwait = 0; end
         idone_p = iDone;
         ddone_p = dDone;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
